// File: rtl/if_stage_if.sv
// Handshake bundle for the instruction-fetch stage: redirect input, instruction-memory
// request/response port and the decode-side instruction slot.
interface if_stage_if #(
  parameter int XLEN = 32
) ();
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [6:0]      Op;
  logic [2:0]      Funct3;
  logic [6:0]      Funct7;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, Op, Funct3, Funct7
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, Op, Funct3, Funct7
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time over a valid/ready
// memory port and presents the fetched instruction (or a NOP bubble) to decode.
module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input logic        clk,
  input logic        rstn,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_p0;
  logic            req_vld_p0;
  logic [XLEN-1:0] req_addr_p0;
  logic            kill;
  logic [31:0]     hold_instr_p1;
  logic [XLEN-1:0] hold_pc_p1;
  logic            vld_p2;
  logic [XLEN-1:0] pc_p2;
  logic [31:0]     instr_p2;
  logic [XLEN-1:0] redir_pc;
  logic            slot_free;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
    return a + XLEN'(4);
  endfunction

  assign redir_pc  = word_align(bus.redirect_pc);
  assign slot_free = ~vld_p2 | bus.id_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      pc_p0         <= RESET_PC;
      req_vld_p0    <= 1'b0;
      req_addr_p0   <= RESET_PC;
      kill          <= 1'b0;
      hold_instr_p1 <= NOP;
      hold_pc_p1    <= '0;
      vld_p2        <= 1'b0;
      pc_p2         <= '0;
      instr_p2      <= NOP;
    end else begin
      if (bus.id_ready) begin
        vld_p2   <= 1'b0;
        instr_p2 <= NOP;
      end

      // p0: request issue; a fresh entry into REQ latches the settled pc one cycle later
      case (state)
        IDLE: begin
          state       <= REQ;
          req_vld_p0  <= 1'b1;
          req_addr_p0 <= pc_p0;
        end
        REQ: begin
          if (!req_vld_p0) begin
            req_vld_p0  <= 1'b1;
            req_addr_p0 <= pc_p0;
          end else if (bus.imem_req_ready) begin
            req_vld_p0 <= 1'b0;
            state      <= WAIT;
          end
        end
        // p1: response capture into the decode slot or the hold buffer
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            state <= REQ;
            if (kill) begin
              kill <= 1'b0;
            end else if (slot_free) begin
              vld_p2   <= 1'b1;
              pc_p2    <= pc_p0;
              instr_p2 <= bus.imem_rsp_data;
              pc_p0    <= next_word(pc_p0);
            end else begin
              hold_instr_p1 <= bus.imem_rsp_data;
              hold_pc_p1    <= pc_p0;
              pc_p0         <= next_word(pc_p0);
              state         <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.id_ready) begin
            vld_p2   <= 1'b1;
            pc_p2    <= hold_pc_p1;
            instr_p2 <= hold_instr_p1;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase

      // A redirect overrides everything above; a request already on the bus is left
      // untouched and its response is marked for discard.
      if (bus.redirect_valid) begin
        pc_p0    <= redir_pc;
        vld_p2   <= 1'b0;
        instr_p2 <= NOP;
        case (state)
          IDLE: req_addr_p0 <= redir_pc;
          REQ: begin
            if (!req_vld_p0) req_addr_p0 <= redir_pc;
            else             kill        <= 1'b1;
          end
          WAIT: begin
            if (bus.imem_rsp_valid) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              kill <= 1'b1;
            end
          end
          HOLD: state <= REQ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // p2: decode-facing outputs
  assign bus.imem_req_valid = req_vld_p0;
  assign bus.imem_req_addr  = req_addr_p0;
  assign bus.id_valid       = vld_p2;
  assign bus.id_pc          = pc_p2;
  assign bus.id_instr       = instr_p2;
  assign bus.Op             = instr_p2[6:0];
  assign bus.Funct3         = instr_p2[14:12];
  assign bus.Funct7         = instr_p2[31:25];

endmodule
